// File: rtl/one_of_n_arb6_ctrl.sv
// Round-robin packet arbiter for a 6:1 output mux.
// A grant is taken on a packet head and held until the tail transfers, so packets never
// interleave on the mux output. On a tail the next grant is chosen in the same cycle, so
// back-to-back packets go out without a bubble. While no grant is held, sel carries the
// null code and the mux outputs zero.
module one_of_n_arb6_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] req,
  input  logic [5:0] last,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic       out_valid,
  output logic [5:0] pop,
  output logic       err_drop
);

  localparam int unsigned NIn      = 6;
  localparam logic [2:0]  SEL_NULL = 3'd7;

  typedef enum logic {
    StIdle,
    StBusy
  } state_e;

  state_e     r_state;
  logic [2:0] r_sel;
  logic       r_valid;
  logic [2:0] r_rr_ptr;
  logic       r_err;

  state_e     w_state;
  logic [2:0] w_sel;
  logic       w_valid;
  logic [2:0] w_rr_ptr;
  logic       w_err;

  logic [5:0] w_grant_oh;   // one-hot of the held grant, zero when idle
  logic       w_g_req;
  logic       w_g_last;
  logic [2:0] w_g_next;     // (g + 1) mod 6
  logic [5:0] w_mask;       // requests with the current grant excluded
  logic [2:0] w_pick_idle;
  logic [2:0] w_pick_rearb;

  // Index following g in the ring 0..5.
  function automatic logic [2:0] inc6(input logic [2:0] g);
    return (g >= 3'd5) ? 3'd0 : g + 3'd1;
  endfunction

  // First set bit of mask scanning ptr, ptr+1, .., wrapping mod 6; SEL_NULL if none.
  // Scanning downwards lets the earliest position in ring order overwrite later ones.
  function automatic logic [2:0] pick(input logic [5:0] mask, input logic [2:0] ptr);
    logic [3:0] idx;
    logic [2:0] res;
    res = SEL_NULL;
    for (int k = int'(NIn) - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(NIn)) begin
        idx = idx - 4'(NIn);
      end
      if (mask[idx[2:0]]) begin
        res = idx[2:0];
      end
    end
    return res;
  endfunction

  // Decode the held grant and precompute both arbitration candidates.
  always_comb begin
    w_grant_oh = '0;
    for (int i = 0; i < int'(NIn); i++) begin
      w_grant_oh[i] = (r_state == StBusy) && (r_sel == 3'(i));
    end
    w_g_req      = |(req & w_grant_oh);
    w_g_last     = |(last & w_grant_oh);
    w_g_next     = inc6(r_sel);
    w_mask       = req & ~w_grant_oh;
    w_pick_idle  = pick(req, r_rr_ptr);
    w_pick_rearb = pick(w_mask, w_g_next);
  end

  // Next-state: grant on head, hold through the packet, re-arbitrate on tail or on a drop.
  always_comb begin
    w_state  = r_state;
    w_sel    = r_sel;
    w_valid  = r_valid;
    w_rr_ptr = r_rr_ptr;
    w_err    = r_err;
    unique case (r_state)
      StIdle: begin
        if (|req) begin
          w_sel   = w_pick_idle;
          w_valid = 1'b1;
          w_state = StBusy;
        end
      end
      StBusy: begin
        // A dropped request ends the packet like a tail, but is flagged as an error.
        if (!w_g_req || (out_ready && w_g_last)) begin
          if (!w_g_req) begin
            w_err = 1'b1;
          end
          w_rr_ptr = w_g_next;
          if (|w_mask) begin
            w_sel = w_pick_rearb;
          end else begin
            w_sel   = SEL_NULL;
            w_valid = 1'b0;
            w_state = StIdle;
          end
        end
      end
      default: begin
        w_state = StIdle;
        w_sel   = SEL_NULL;
        w_valid = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_sel    <= SEL_NULL;
      r_valid  <= 1'b0;
      r_rr_ptr <= 3'd0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_sel    <= w_sel;
      r_valid  <= w_valid;
      r_rr_ptr <= w_rr_ptr;
      r_err    <= w_err;
    end
  end

  // Pop only the granted buffer, and only on an accepted flit it actually presents.
  always_comb begin
    pop = '0;
    if (r_valid && out_ready) begin
      pop = w_grant_oh & req;
    end
  end

  assign sel       = r_sel;
  assign out_valid = r_valid;
  assign err_drop  = r_err;

endmodule

// File: tb/tb_one_of_n_arb6_ctrl.sv
// Directed bench for the round-robin packet arbiter.
module tb_one_of_n_arb6_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] req;
  logic [5:0] last;
  logic       out_ready;
  logic [2:0] sel;
  logic       out_valid;
  logic [5:0] pop;
  logic       err_drop;

  int n_checks;
  int n_pass;
  int pops;

  one_of_n_arb6_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .out_ready (out_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .pop       (pop),
    .err_drop  (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    req       = 6'h3F;
    last      = 6'h00;
    out_ready = 1'b0;

    // 1 reset with all requests high
    cyc();
    cyc();
    check("rst_sel", 8'(sel), 8'd7);
    check("rst_valid", 8'(out_valid), 8'd0);
    check("rst_pop", 8'(pop), 8'd0);
    check("rst_err", 8'(err_drop), 8'd0);
    rst_n = 1'b1;
    req   = 6'h00;
    cyc();
    check("idle_sel", 8'(sel), 8'd7);

    // 2 single-flit packet on input 2
    req       = 6'b000100;
    last      = 6'b000100;
    out_ready = 1'b1;
    settle();
    check("single_nopop_idle", 8'(pop), 8'd0);
    cyc();
    check("single_sel", 8'(sel), 8'd2);
    check("single_valid", 8'(out_valid), 8'd1);
    check("single_pop", 8'(pop), 8'b000100);
    cyc();
    req  = 6'h00;
    last = 6'h00;
    settle();
    check("single_end_sel", 8'(sel), 8'd7);
    check("single_end_valid", 8'(out_valid), 8'd0);
    check("single_end_pop", 8'(pop), 8'd0);

    // 3 four-flit packet on input 0 with a stall, req[3] raised mid-packet (rr_ptr=3 now)
    req = 6'b000001;
    settle();
    check("pkt_latency_valid", 8'(out_valid), 8'd0);
    cyc();
    pops = 0;
    // flit 1
    out_ready = 1'b1;
    settle();
    check("pkt_sel_a", 8'(sel), 8'd0);
    pops += int'(pop[0]);
    cyc();
    // stall cycle, requestor 3 appears
    out_ready = 1'b0;
    req       = 6'b001001;
    settle();
    check("pkt_sel_b", 8'(sel), 8'd0);
    check("pkt_stall_pop", 8'(pop), 8'd0);
    pops += int'(pop[0]);
    cyc();
    // flits 2 and 3
    out_ready = 1'b1;
    settle();
    check("pkt_sel_c", 8'(sel), 8'd0);
    check("pkt_nopreempt_pop", 8'(pop), 8'b000001);
    pops += int'(pop[0]);
    cyc();
    check("pkt_sel_d", 8'(sel), 8'd0);
    pops += int'(pop[0]);
    cyc();
    // tail flit
    last = 6'b000001;
    settle();
    check("pkt_sel_e", 8'(sel), 8'd0);
    pops += int'(pop[0]);
    cyc();
    check("pkt_pop_count", 8'(pops), 8'd4);
    req  = 6'b001000;
    last = 6'b001000;
    settle();
    check("pkt_next_sel", 8'(sel), 8'd3);
    check("pkt_next_pop", 8'(pop), 8'b001000);
    cyc();
    req  = 6'h00;
    last = 6'h00;
    settle();
    check("pkt_idle_valid", 8'(out_valid), 8'd0);

    // 4 rotation after a fresh reset (rr_ptr=0), all single-flit
    rst_n = 1'b0;
    cyc();
    rst_n     = 1'b1;
    req       = 6'h3F;
    last      = 6'h3F;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      check($sformatf("rot_sel_%0d", i), 8'(sel), 8'(i % 6));
      check($sformatf("rot_valid_%0d", i), 8'(out_valid), 8'd1);
    end

    // 5 wrap and exclusion: only 0 and 5 requesting, grant 0 held now
    req  = 6'b100001;
    last = 6'b100001;
    cyc();
    check("wrap_sel_5", 8'(sel), 8'd5);
    cyc();
    check("wrap_sel_0", 8'(sel), 8'd0);
    cyc();
    check("wrap_sel_5b", 8'(sel), 8'd5);
    req  = 6'b100000;
    last = 6'b100000;
    cyc();
    req  = 6'h00;
    last = 6'h00;
    settle();
    check("wrap_idle_valid", 8'(out_valid), 8'd0);
    check("wrap_idle_sel", 8'(sel), 8'd7);

    // 6 drop error on grant 4 (rr_ptr=0 now)
    req       = 6'b010000;
    last      = 6'h00;
    out_ready = 1'b1;
    cyc();
    check("err_grant_sel", 8'(sel), 8'd4);
    check("err_pop", 8'(pop), 8'b010000);
    cyc();
    check("err_before", 8'(err_drop), 8'd0);
    // drop req[4]; 0 and 5 pending, scan from 5 picks 5
    req = 6'b100001;
    cyc();
    check("err_set", 8'(err_drop), 8'd1);
    check("err_rearb_sel", 8'(sel), 8'd5);
    check("err_rearb_valid", 8'(out_valid), 8'd1);
    cyc();
    cyc();
    check("err_sticky", 8'(err_drop), 8'd1);
    check("err_hold_sel", 8'(sel), 8'd5);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    req   = 6'h00;
    settle();
    check("midpkt_rst_sel", 8'(sel), 8'd7);
    check("midpkt_rst_valid", 8'(out_valid), 8'd0);
    check("midpkt_rst_pop", 8'(pop), 8'd0);
    check("midpkt_rst_err", 8'(err_drop), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop if stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
